// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST response-analysis path of the 6:3 counter.
package bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } bist_state_e;

  localparam int unsigned MISR_W_DEF    = 16;
  localparam logic [15:0] MISR_POLY_DEF = 16'h1021;

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Galois-feedback MISR: synchronous seed load, enable-gated compaction of a small data word.
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned          MISR_W = MISR_W_DEF,
  parameter int unsigned          DIN_W  = 3,
  parameter logic [MISR_W-1:0]    POLY   = MISR_POLY_DEF,
  parameter logic [MISR_W-1:0]    SEED   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [DIN_W-1:0]  i_din,
  output logic [MISR_W-1:0] o_sig
);

  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] w_next;

  always_comb begin
    w_next = (r_sig << 1) ^ (r_sig[MISR_W-1] ? POLY : '0) ^ MISR_W'(i_din);
  end

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/bist_response_analyzer.sv
// Checks each 6:3 counter result against a reference popcount, compacts results in a MISR,
// and reports a registered pass/fail verdict after NUM_PATTERNS valid samples.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned       NUM_PATTERNS = 64,
  parameter int unsigned       CNT_W        = 8,
  parameter int unsigned       MISR_W       = MISR_W_DEF,
  parameter logic [MISR_W-1:0] MISR_POLY    = MISR_POLY_DEF,
  parameter logic [MISR_W-1:0] MISR_SEED    = '1,
  parameter logic [MISR_W-1:0] GOLDEN_SIG   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pat_valid,
  input  logic [5:0]        pattern,
  input  logic [2:0]        cut_sum,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic              first_fail_vld,
  output logic [MISR_W-1:0] signature
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);

  bist_state_e      r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_sig_match;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_ffi;
  logic             r_ffv;

  logic             w_start_ok;
  logic             w_sample;
  logic             w_mismatch;
  logic [MISR_W-1:0] w_sig;

  always_comb begin
    w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
    w_sample   = pat_valid && (r_state == S_RUN);
    w_mismatch = (cut_sum != popcount6(pattern));
  end

  bist_misr #(
    .MISR_W (MISR_W),
    .DIN_W  (3),
    .POLY   (MISR_POLY),
    .SEED   (MISR_SEED)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start_ok),
    .i_en   (w_sample),
    .i_din  (cut_sum),
    .o_sig  (w_sig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_sig_match <= 1'b0;
      r_idx       <= '0;
      r_err       <= '0;
      r_ffi       <= '0;
      r_ffv       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // The verdict registers one cycle after entering DONE; a start overrides it below.
          if (r_state == S_DONE) begin
            r_done <= 1'b1;
            r_pass <= r_sig_match && (r_err == '0);
          end
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_idx   <= '0;
            r_err   <= '0;
            r_ffi   <= '0;
            r_ffv   <= 1'b0;
          end
        end
        S_RUN: begin
          if (pat_valid) begin
            if (w_mismatch) begin
              if (r_err != '1) begin
                r_err <= r_err + 1'b1;
              end
              if (!r_ffv) begin
                r_ffi <= r_idx;
                r_ffv <= 1'b1;
              end
            end
            if (r_idx == LAST_IDX) begin
              r_state <= S_COMPARE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_COMPARE: begin
          r_sig_match <= (w_sig == GOLDEN_SIG);
          r_state     <= S_DONE;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err;
  assign first_fail_idx = r_ffi;
  assign first_fail_vld = r_ffv;
  assign signature      = w_sig;

endmodule
